// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-multiplier stream host.
// - ELEM_W       : width of one stream word (one IEEE-754 double)
// - mat_words(n) : number of 64-bit words in one complex n x n matrix
// - host_state_t : host FSM state encoding
package mat_pkg;

  localparam int ELEM_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE_V,
    ST_ISSUE_S1,
    ST_ISSUE_S2,
    ST_WAIT,
    ST_DRAIN
  } host_state_t;

  // A complex n x n matrix is n*n real words followed by n*n imag words.
  function automatic int mat_words(input int n);
    return 2 * n * n;
  endfunction

endpackage

// File: rtl/mat_mult_stream_host_if.sv
// Bundle of the host's stream and multiplier-side signals.
// - in_*      : operand word stream into the host
// - out_*     : result word stream out of the host
// - mm_*      : parallel buses and handshake to/from mat_mult_complex
// - busy, err_len, err_timeout : status
// The slave modport is the host's view; master is the environment's view.
interface mat_mult_stream_host_if #(
  parameter int mat_num_row = 2
);
  import mat_pkg::*;

  localparam int BUS_W = ELEM_W * mat_words(mat_num_row);

  logic [ELEM_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;
  logic [BUS_W-1:0]  mm_mat_a;
  logic [BUS_W-1:0]  mm_mat_b;
  logic              mm_valid;
  logic              mm_start;
  logic [BUS_W-1:0]  mm_mat_out;
  logic              mm_done;
  logic              busy;
  logic              err_len;
  logic              err_timeout;

  modport slave (
    input  in_data, in_valid, in_last, out_ready, mm_mat_out, mm_done,
    output in_ready, out_data, out_valid, out_last,
           mm_mat_a, mm_mat_b, mm_valid, mm_start,
           busy, err_len, err_timeout
  );

  modport master (
    output in_data, in_valid, in_last, out_ready, mm_mat_out, mm_done,
    input  in_ready, out_data, out_valid, out_last,
           mm_mat_a, mm_mat_b, mm_valid, mm_start,
           busy, err_len, err_timeout
  );

endinterface

// File: rtl/mat_word_serializer.sv
// Holds one captured result matrix and streams it out word by word.
// - load/load_data : capture a result and start presenting word 0 next cycle
// - out_data/out_valid/out_last/out_ready : valid/ready result stream
// - drained        : one-cycle pulse, high during the final word's handshake
module mat_word_serializer
  import mat_pkg::*;
#(
  parameter  int mat_num_row = 2,
  localparam int RES_WORDS   = mat_words(mat_num_row),
  localparam int BUS_W       = ELEM_W * RES_WORDS,
  localparam int IDX_W       = $clog2(RES_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BUS_W-1:0]  load_data,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              drained
);

  logic [BUS_W-1:0] buf_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             valid_reg;
  logic             last_word;
  logic             handshake;

  assign last_word = (idx_reg == IDX_W'(RES_WORDS - 1));
  assign handshake = valid_reg && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      buf_reg   <= load_data;
      idx_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (handshake) begin
      if (last_word) begin
        valid_reg <= 1'b0;
        idx_reg   <= '0;
      end else begin
        idx_reg   <= idx_reg + 1'b1;
      end
    end
  end

  // Data and last are pure functions of registers, so they hold while stalled.
  assign out_data  = buf_reg[int'(idx_reg) * ELEM_W +: ELEM_W];
  assign out_valid = valid_reg;
  assign out_last  = valid_reg && last_word;
  assign drained   = handshake && last_word;

endmodule

// File: rtl/mat_mult_stream_host.sv
// Stream-side host for mat_mult_complex.
// - clk, rst : clock and asynchronous active-high reset (shared with multiplier)
// - bus      : operand stream in, result stream out, multiplier buses and
//              valid/start/done handshake, busy and error pulses
// Operand words 0..4N^2-1 fill {mm_mat_b, mm_mat_a}; the multiplier is then
// kicked with valid -> valid+start -> start, and the captured result is
// streamed out as 2N^2 words.
module mat_mult_stream_host
  import mat_pkg::*;
#(
  parameter int mat_num_row = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                  clk,
  input logic                  rst,
  mat_mult_stream_host_if.slave bus
);

  localparam int RES_WORDS  = mat_words(mat_num_row);
  localparam int LOAD_WORDS = 2 * RES_WORDS;
  localparam int BUS_W      = ELEM_W * RES_WORDS;
  localparam int LOAD_W     = $clog2(LOAD_WORDS + 1);
  localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1);

  host_state_t       state_reg, state_next;
  logic [LOAD_W-1:0] load_idx_reg, load_idx_next;
  logic [TMO_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              err_len_reg, err_len_next;
  logic              err_timeout_reg, err_timeout_next;
  logic [ELEM_W-1:0] operand_reg [LOAD_WORDS];

  logic in_ready;
  logic accept;
  logic last_beat;
  logic mm_valid_c;
  logic mm_start_c;
  logic ser_load;
  logic drained;

  // Gate with rst so the stream is refused for the whole reset interval.
  assign in_ready  = !rst && (state_reg == ST_IDLE || state_reg == ST_LOAD);
  assign accept    = bus.in_valid && in_ready;
  assign last_beat = (load_idx_reg == LOAD_W'(LOAD_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      load_idx_reg    <= '0;
      wait_cnt_reg    <= '0;
      err_len_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      load_idx_reg    <= load_idx_next;
      wait_cnt_reg    <= wait_cnt_next;
      err_len_reg     <= err_len_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  // Operand words are only written on accepted beats, so the multiplier
  // inputs stay frozen from the end of LOAD through DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOAD_WORDS; i++) operand_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < LOAD_WORDS; i++) begin
        if (load_idx_reg == LOAD_W'(i)) operand_reg[i] <= bus.in_data;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    load_idx_next    = load_idx_reg;
    wait_cnt_next    = wait_cnt_reg;
    err_len_next     = 1'b0;
    err_timeout_next = 1'b0;
    mm_valid_c       = 1'b0;
    mm_start_c       = 1'b0;
    ser_load         = 1'b0;
    case (state_reg)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          if (bus.in_last && !last_beat) begin
            // Short job: drop it without touching the multiplier.
            err_len_next  = 1'b1;
            load_idx_next = '0;
            state_next    = ST_IDLE;
          end else if (last_beat) begin
            // Missing in_last is flagged but the full job still runs.
            err_len_next  = !bus.in_last;
            load_idx_next = '0;
            state_next    = ST_ISSUE_V;
          end else begin
            load_idx_next = load_idx_reg + 1'b1;
            state_next    = ST_LOAD;
          end
        end
      end
      ST_ISSUE_V: begin
        mm_valid_c = 1'b1;
        state_next = ST_ISSUE_S1;
      end
      ST_ISSUE_S1: begin
        mm_valid_c = 1'b1;
        mm_start_c = 1'b1;
        state_next = ST_ISSUE_S2;
      end
      ST_ISSUE_S2: begin
        mm_start_c    = 1'b1;
        wait_cnt_next = '0;
        state_next    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mm_done) begin
          ser_load   = 1'b1;
          state_next = ST_DRAIN;
        end else if (wait_cnt_reg + 1'b1 == TMO_W'(TIMEOUT_CYC)) begin
          err_timeout_next = 1'b1;
          wait_cnt_next    = '0;
          state_next       = ST_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drained) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mat_word_serializer #(
    .mat_num_row (mat_num_row)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_data (bus.mm_mat_out),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_last  (bus.out_last),
    .out_ready (bus.out_ready),
    .drained   (drained)
  );

  for (genvar gi = 0; gi < RES_WORDS; gi++) begin : g_flatten
    assign bus.mm_mat_a[gi*ELEM_W +: ELEM_W] = operand_reg[gi];
    assign bus.mm_mat_b[gi*ELEM_W +: ELEM_W] = operand_reg[RES_WORDS + gi];
  end

  assign bus.in_ready    = in_ready;
  assign bus.mm_valid    = mm_valid_c;
  assign bus.mm_start    = mm_start_c;
  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.err_len     = err_len_reg;
  assign bus.err_timeout = err_timeout_reg;

endmodule
